// File: rtl/multicycle_ctrl_unit.sv
// Multi-cycle RV32I control unit: sequences each instruction through
// fetch/decode/execute/mem/writeback with bounded-wait bus handshakes,
// optional M-extension sequencing and sticky fault flags.
module multicycle_ctrl_unit #(
  parameter bit          ENABLE_M    = 1'b1,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] instr_i,
  input  logic        br_less_i,
  input  logic        br_equal_i,
  input  logic        imem_ack_i,
  input  logic        dmem_ack_i,
  input  logic        muldiv_done_i,
  output logic        imem_req_o,
  output logic        dmem_req_o,
  output logic        ir_wren_o,
  output logic        pc_wren_o,
  output logic        rd_wren_o,
  output logic        mem_wren_o,
  output logic        muldiv_start_o,
  output logic [2:0]  muldiv_op_o,
  output logic        wb_muldiv_o,
  output logic        br_sel_o,
  output logic        br_unsigned_o,
  output logic        op_a_sel_o,
  output logic        op_b_sel_o,
  output logic [3:0]  alu_op_o,
  output logic [2:0]  mem_op_o,
  output logic [1:0]  wb_sel_o,
  output logic        illegal_o,
  output logic        bus_err_o,
  output logic [2:0]  state_o
);

  localparam int unsigned CntW = 8;
  localparam bit TimeoutEn = (ACK_TIMEOUT != 0);
  localparam logic [CntW-1:0] CntLimit = TimeoutEn ? CntW'(ACK_TIMEOUT - 1) : '0;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpFence  = 7'b0001111;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_MULDIV    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_TRAP      = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic            illegal_q, bus_err_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_load, is_store, is_branch, is_fence, is_mulop, is_muldiv;
  logic       known_op, illegal_c, limit_hit, bus_req, bus_ack;
  logic       unused_instr;

  // Instruction classification shared by sequencing and datapath decode
  assign opcode    = instr_i[6:0];
  assign funct3    = instr_i[14:12];
  assign is_load   = (opcode == OpLoad);
  assign is_store  = (opcode == OpStore);
  assign is_branch = (opcode == OpBranch);
  assign is_fence  = (opcode == OpFence);
  assign is_mulop  = (opcode == OpReg) && (instr_i[31:25] == 7'b0000001);
  assign is_muldiv = is_mulop && ENABLE_M;
  assign known_op  = (opcode == OpLui)   || (opcode == OpAuipc) || (opcode == OpJal) ||
                     (opcode == OpJalr)  || is_branch || is_load || is_store ||
                     (opcode == OpImm)   || (opcode == OpReg)   || is_fence;
  // SYSTEM is outside known_op, so it lands here as illegal too
  assign illegal_c = !known_op || (is_mulop && !ENABLE_M);
  assign unused_instr = ^{instr_i[24:15], instr_i[11:7]};

  // Bus handshake view for the timeout counter
  assign bus_req   = (state_q == S_FETCH) || (state_q == S_MEM);
  assign bus_ack   = (state_q == S_FETCH) ? imem_ack_i : dmem_ack_i;
  assign limit_hit = TimeoutEn && (cnt_q == CntLimit);

  assign state_o   = state_q;
  assign illegal_o = illegal_q;
  assign bus_err_o = bus_err_q;

  // State register, wait-cycle counter and sticky fault flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM))) begin
        cnt_q <= '0;
      end else if (bus_req && !bus_ack && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CntW'(1);
      end
      if ((state_q == S_DECODE) && (state_d == S_TRAP)) begin
        illegal_q <= 1'b1;
      end
      if (bus_req && (state_d == S_TRAP)) begin
        bus_err_q <= 1'b1;
      end
    end
  end

  // Next-state sequencing; an ack on the limit cycle still completes
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: begin
        if (imem_ack_i)     state_d = S_DECODE;
        else if (limit_hit) state_d = S_TRAP;
      end
      S_DECODE:  state_d = illegal_c ? S_TRAP : S_EXECUTE;
      S_EXECUTE: begin
        if (is_load || is_store) state_d = S_MEM;
        else if (is_muldiv)      state_d = S_MULDIV;
        else                     state_d = S_WRITEBACK;
      end
      S_MEM: begin
        if (dmem_ack_i)     state_d = is_store ? S_FETCH : S_WRITEBACK;
        else if (limit_hit) state_d = S_TRAP;
      end
      S_MULDIV:    if (muldiv_done_i) state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_FETCH;
    endcase
  end

  // State-gated strobes plus combinational datapath selects from instr_i
  always_comb begin
    imem_req_o     = 1'b0;
    dmem_req_o     = 1'b0;
    ir_wren_o      = 1'b0;
    pc_wren_o      = 1'b0;
    rd_wren_o      = 1'b0;
    mem_wren_o     = 1'b0;
    muldiv_start_o = 1'b0;
    wb_muldiv_o    = 1'b0;
    muldiv_op_o    = is_muldiv ? funct3 : 3'b000;
    br_sel_o       = 1'b0;
    br_unsigned_o  = 1'b0;
    op_a_sel_o     = 1'b0;
    op_b_sel_o     = 1'b0;
    alu_op_o       = 4'b0000;
    mem_op_o       = 3'b000;
    wb_sel_o       = 2'd0;

    unique case (state_q)
      S_FETCH: begin
        imem_req_o = 1'b1;
        ir_wren_o  = imem_ack_i;
      end
      S_EXECUTE: muldiv_start_o = is_muldiv;
      S_MEM: begin
        dmem_req_o = 1'b1;
        mem_wren_o = is_store;
        pc_wren_o  = is_store && dmem_ack_i;
      end
      S_MULDIV: wb_muldiv_o = 1'b1;
      S_WRITEBACK: begin
        pc_wren_o   = 1'b1;
        rd_wren_o   = !(is_branch || is_fence);
        wb_muldiv_o = is_muldiv;
      end
      default: ;
    endcase

    case (opcode)
      OpLui: begin
        op_b_sel_o = 1'b1;
        wb_sel_o   = 2'd3;
      end
      OpAuipc: begin
        op_a_sel_o = 1'b1;
        op_b_sel_o = 1'b1;
      end
      OpJal: begin
        br_sel_o   = 1'b1;
        op_a_sel_o = 1'b1;
        op_b_sel_o = 1'b1;
        wb_sel_o   = 2'd2;
      end
      OpJalr: begin
        br_sel_o   = 1'b1;
        op_b_sel_o = 1'b1;
        wb_sel_o   = 2'd2;
      end
      OpBranch: begin
        op_a_sel_o    = 1'b1;
        op_b_sel_o    = 1'b1;
        br_unsigned_o = (funct3[2:1] == 2'b11);
        case (funct3)
          3'b000:         br_sel_o = br_equal_i;
          3'b001:         br_sel_o = !br_equal_i;
          3'b100, 3'b110: br_sel_o = br_less_i;
          3'b101, 3'b111: br_sel_o = !br_less_i;
          default:        br_sel_o = 1'b0;
        endcase
      end
      OpLoad: begin
        op_b_sel_o = 1'b1;
        mem_op_o   = funct3;
        wb_sel_o   = 2'd1;
      end
      OpStore: begin
        op_b_sel_o = 1'b1;
        mem_op_o   = funct3;
      end
      OpImm: begin
        op_b_sel_o = 1'b1;
        alu_op_o   = {((funct3 == 3'b001) || (funct3 == 3'b101)) ? instr_i[30] : 1'b0, funct3};
      end
      OpReg: alu_op_o = {instr_i[30], funct3};
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// Directed bench for multicycle_ctrl_unit: decode vector table plus
// hand-built multi-cycle sequences (waits, M-unit, timeouts, resets).
module tb_multicycle_ctrl_unit;

  localparam int MAXC = 64;
  localparam logic [2:0] ST_F = 3'd0, ST_D = 3'd1, ST_E = 3'd2, ST_M = 3'd3;
  localparam logic [2:0] ST_MD = 3'd4, ST_WB = 3'd5, ST_T = 3'd6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] instr = '0;
  logic        br_less = 1'b0, br_equal = 1'b0;
  logic        imem_ack = 1'b0, dmem_ack = 1'b0, md_done = 1'b0;

  logic imem_req, dmem_req, ir_wren, pc_wren, rd_wren, mem_wren, md_start, wb_md;
  logic br_sel, br_un, op_a, op_b, illegal, bus_err;
  logic [2:0] md_op, mem_op, state;
  logic [3:0] alu_op;
  logic [1:0] wb_sel;

  logic nm_imem_req, nm_dmem_req, nm_ir_wren, nm_pc_wren, nm_rd_wren, nm_mem_wren;
  logic nm_md_start, nm_wb_md, nm_br_sel, nm_br_un, nm_op_a, nm_op_b, nm_illegal, nm_bus_err;
  logic [2:0] nm_md_op, nm_mem_op, nm_state;
  logic [3:0] nm_alu_op;
  logic [1:0] nm_wb_sel;

  multicycle_ctrl_unit #(.ENABLE_M(1'b1), .ACK_TIMEOUT(16)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .instr_i(instr), .br_less_i(br_less), .br_equal_i(br_equal),
    .imem_ack_i(imem_ack), .dmem_ack_i(dmem_ack), .muldiv_done_i(md_done),
    .imem_req_o(imem_req), .dmem_req_o(dmem_req), .ir_wren_o(ir_wren), .pc_wren_o(pc_wren),
    .rd_wren_o(rd_wren), .mem_wren_o(mem_wren), .muldiv_start_o(md_start), .muldiv_op_o(md_op),
    .wb_muldiv_o(wb_md), .br_sel_o(br_sel), .br_unsigned_o(br_un), .op_a_sel_o(op_a),
    .op_b_sel_o(op_b), .alu_op_o(alu_op), .mem_op_o(mem_op), .wb_sel_o(wb_sel),
    .illegal_o(illegal), .bus_err_o(bus_err), .state_o(state));

  multicycle_ctrl_unit #(.ENABLE_M(1'b0), .ACK_TIMEOUT(16)) u_dut_nm (
    .clk_i(clk), .rst_ni(rst_n), .instr_i(instr), .br_less_i(br_less), .br_equal_i(br_equal),
    .imem_ack_i(imem_ack), .dmem_ack_i(dmem_ack), .muldiv_done_i(md_done),
    .imem_req_o(nm_imem_req), .dmem_req_o(nm_dmem_req), .ir_wren_o(nm_ir_wren),
    .pc_wren_o(nm_pc_wren), .rd_wren_o(nm_rd_wren), .mem_wren_o(nm_mem_wren),
    .muldiv_start_o(nm_md_start), .muldiv_op_o(nm_md_op), .wb_muldiv_o(nm_wb_md),
    .br_sel_o(nm_br_sel), .br_unsigned_o(nm_br_un), .op_a_sel_o(nm_op_a), .op_b_sel_o(nm_op_b),
    .alu_op_o(nm_alu_op), .mem_op_o(nm_mem_op), .wb_sel_o(nm_wb_sel),
    .illegal_o(nm_illegal), .bus_err_o(nm_bus_err), .state_o(nm_state));

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic        less, equal;
    logic [15:0] exp;  // {alu_op, br_sel, br_un, op_a, op_b, wb_sel, mem_op, md_op}
  } vec_t;

  function automatic vec_t mk(input logic [31:0] i, input logic l, input logic e,
                              input logic [3:0] alu, input logic bs, input logic bu,
                              input logic a, input logic b, input logic [1:0] wb,
                              input logic [2:0] mo, input logic [2:0] mdo);
    vec_t v;
    v.instr = i; v.less = l; v.equal = e;
    v.exp = {alu, bs, bu, a, b, wb, mo, mdo};
    return v;
  endfunction

  // Per-instruction trace captured by exec
  logic [2:0] tr_state [MAXC];
  int n_ir, n_pc, n_rd, n_memw, n_dreq, n_start, n_wbmd;
  logic last_rd, last_pc, last_wbmd, last_brsel, last_bus_err, last_illegal;
  logic [1:0] last_wbsel;
  logic [2:0] last_state;

  // Runs one instruction with the given ack/done wait counts (memory/M-unit model)
  task automatic exec(input logic [31:0] ins, input int iw, input int dw, input int mw,
                      output int n);
    int ic, dc, mc;
    bit done;
    ic = 0; dc = 0; mc = 0; n = 0; done = 1'b0;
    n_ir = 0; n_pc = 0; n_rd = 0; n_memw = 0; n_dreq = 0; n_start = 0; n_wbmd = 0;
    for (int c = 0; c < MAXC && !done; c++) begin
      @(negedge clk);
      instr = ins;
      #1;
      imem_ack = imem_req && (ic == iw);
      dmem_ack = dmem_req && (dc == dw);
      md_done  = (state == ST_MD) && (mc == mw - 1);
      #1;
      tr_state[c] = state;
      n_ir += int'(ir_wren);   n_pc += int'(pc_wren);   n_rd += int'(rd_wren);
      n_memw += int'(mem_wren); n_dreq += int'(dmem_req); n_start += int'(md_start);
      n_wbmd += int'(wb_md);
      last_rd = rd_wren; last_pc = pc_wren; last_wbmd = wb_md; last_brsel = br_sel;
      last_wbsel = wb_sel; last_state = state; last_bus_err = bus_err; last_illegal = illegal;
      if (imem_req) ic++;
      if (dmem_req) dc++;
      if (state == ST_MD) mc++;
      n = c + 1;
      if (pc_wren || state == ST_T) done = 1'b1;
    end
  endtask

  task automatic release_rst();
    imem_ack = 1'b0; dmem_ack = 1'b0; md_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    release_rst();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs[$];
    int n;

    vecs.push_back(mk(32'h002081B3, 0, 0, 4'h0, 0, 0, 0, 0, 2'd0, 3'd0, 3'd0)); // ADD
    vecs.push_back(mk(32'h402081B3, 0, 0, 4'h8, 0, 0, 0, 0, 2'd0, 3'd0, 3'd0)); // SUB
    vecs.push_back(mk(32'h4040D193, 0, 0, 4'hD, 0, 0, 0, 1, 2'd0, 3'd0, 3'd0)); // SRAI
    vecs.push_back(mk(32'h40000093, 0, 0, 4'h0, 0, 0, 0, 1, 2'd0, 3'd0, 3'd0)); // ADDI imm[10]=1
    vecs.push_back(mk(32'h123450B7, 0, 0, 4'h0, 0, 0, 0, 1, 2'd3, 3'd0, 3'd0)); // LUI
    vecs.push_back(mk(32'h00001097, 0, 0, 4'h0, 0, 0, 1, 1, 2'd0, 3'd0, 3'd0)); // AUIPC
    vecs.push_back(mk(32'h008000EF, 0, 0, 4'h0, 1, 0, 1, 1, 2'd2, 3'd0, 3'd0)); // JAL
    vecs.push_back(mk(32'h000100E7, 0, 0, 4'h0, 1, 0, 0, 1, 2'd2, 3'd0, 3'd0)); // JALR
    vecs.push_back(mk(32'h00208463, 0, 1, 4'h0, 1, 0, 1, 1, 2'd0, 3'd0, 3'd0)); // BEQ taken
    vecs.push_back(mk(32'h00208463, 0, 0, 4'h0, 0, 0, 1, 1, 2'd0, 3'd0, 3'd0)); // BEQ not taken
    vecs.push_back(mk(32'h00209463, 0, 0, 4'h0, 1, 0, 1, 1, 2'd0, 3'd0, 3'd0)); // BNE taken
    vecs.push_back(mk(32'h0020E463, 1, 0, 4'h0, 1, 1, 1, 1, 2'd0, 3'd0, 3'd0)); // BLTU taken
    vecs.push_back(mk(32'h0020F463, 1, 0, 4'h0, 0, 1, 1, 1, 2'd0, 3'd0, 3'd0)); // BGEU not taken
    vecs.push_back(mk(32'h0020D463, 0, 0, 4'h0, 1, 0, 1, 1, 2'd0, 3'd0, 3'd0)); // BGE taken
    vecs.push_back(mk(32'h0000A183, 0, 0, 4'h0, 0, 0, 0, 1, 2'd1, 3'd2, 3'd0)); // LW
    vecs.push_back(mk(32'h0020A023, 0, 0, 4'h0, 0, 0, 0, 1, 2'd0, 3'd2, 3'd0)); // SW
    vecs.push_back(mk(32'h0000C183, 0, 0, 4'h0, 0, 0, 0, 1, 2'd1, 3'd4, 3'd0)); // LBU
    vecs.push_back(mk(32'h0220D1B3, 0, 0, 4'h5, 0, 0, 0, 0, 2'd0, 3'd0, 3'd5)); // DIVU

    #1 rst_n = 1'b0;
    #1;
    chk("reset_state", 32'(state), 32'(ST_F));
    chk("reset_imem_req", 32'(imem_req), 32'd1);
    chk("reset_strobes", 32'({dmem_req, ir_wren, pc_wren, rd_wren, mem_wren, md_start, wb_md}), 32'd0);
    chk("reset_flags", 32'({illegal, bus_err}), 32'd0);

    // Datapath decode is combinational in every state; apply it while held in reset
    for (int i = 0; i < vecs.size(); i++) begin
      instr = vecs[i].instr; br_less = vecs[i].less; br_equal = vecs[i].equal;
      #1;
      chk($sformatf("decode[%0d]", i),
          32'({alu_op, br_sel, br_un, op_a, op_b, wb_sel, mem_op, md_op}), 32'(vecs[i].exp));
    end
    br_less = 1'b0; br_equal = 1'b0;
    release_rst();

    // ADD, zero-wait fetch
    exec(32'h002081B3, 0, 0, 1, n);
    chk("add_cycles", 32'(n), 32'd4);
    chk("add_states", 32'({tr_state[0], tr_state[1], tr_state[2], tr_state[3]}),
        32'({ST_F, ST_D, ST_E, ST_WB}));
    chk("add_strobe_counts", 32'({n_ir[3:0], n_pc[3:0], n_rd[3:0]}), 32'h111);
    chk("add_last_wr", 32'({last_rd, last_pc}), 32'b11);

    // ADD with 3 fetch wait cycles
    exec(32'h002081B3, 3, 0, 1, n);
    chk("add_wait_cycles", 32'(n), 32'd7);

    // SW, zero-wait
    exec(32'h0020A023, 0, 0, 1, n);
    chk("sw_cycles", 32'(n), 32'd4);
    chk("sw_counts", 32'({n_memw[3:0], n_dreq[3:0], n_rd[3:0], n_pc[3:0]}), 32'h1101);
    chk("sw_last_state", 32'(last_state), 32'(ST_M));

    // LW, dmem ack after 3 wait cycles
    exec(32'h0000A183, 0, 3, 1, n);
    chk("lw_cycles", 32'(n), 32'd8);
    chk("lw_dreq_memw", 32'({n_dreq[3:0], n_memw[3:0]}), 32'h40);
    chk("lw_wb", 32'({last_state, last_wbsel, last_rd}), 32'({ST_WB, 2'd1, 1'b1}));

    // BEQ taken / not taken
    br_equal = 1'b1;
    exec(32'h00208463, 0, 0, 1, n);
    chk("beq_t_wb", 32'({n[3:0], last_brsel, last_pc, last_rd}), 32'({4'd4, 3'b110}));
    br_equal = 1'b0;
    exec(32'h00208463, 0, 0, 1, n);
    chk("beq_nt_wb", 32'({n[3:0], last_brsel, last_pc, n_rd[3:0]}), 32'({4'd4, 2'b01, 4'd0}));

    // FENCE behaves as a NOP
    exec(32'h0000000F, 0, 0, 1, n);
    chk("fence", 32'({n[3:0], n_pc[3:0], n_rd[3:0]}), 32'h410);

    // MUL, done on the 5th M-unit cycle
    exec(32'h022081B3, 0, 0, 5, n);
    chk("mul_cycles", 32'(n), 32'd9);
    chk("mul_start_pulse", 32'({n_start[3:0], tr_state[2], tr_state[3]}), 32'({4'd1, ST_E, ST_MD}));
    chk("mul_wbmd", 32'({n_wbmd[3:0], last_wbmd, last_rd}), 32'({4'd6, 2'b11}));

    // LW with ack exactly on the 16th MEM cycle completes normally
    exec(32'h0000A183, 0, 15, 1, n);
    chk("lw_limit_ack", 32'({n[7:0], last_state, last_bus_err}), 32'({8'd20, ST_WB, 1'b0}));

    // LW with no dmem ack -> bus error trap
    exec(32'h0000A183, 0, 999, 1, n);
    chk("lw_timeout", 32'({n[7:0], last_state, last_bus_err, last_illegal}),
        32'({8'd20, ST_T, 2'b10}));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("bus_err_async_clear", 32'({state, bus_err, imem_req}), 32'({ST_F, 2'b01}));
    release_rst();

    // ECALL is illegal; TRAP absorbs everything
    exec(32'h00000073, 0, 0, 1, n);
    chk("ecall_trap", 32'({tr_state[0], tr_state[1], tr_state[2], last_illegal, last_bus_err}),
        32'({ST_F, ST_D, ST_T, 2'b10}));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      instr = 32'h002081B3; imem_ack = 1'b1; dmem_ack = 1'b1; md_done = 1'b1;
      #2;
      chk($sformatf("trap_quiet[%0d]", c),
          32'({state, imem_req, dmem_req, ir_wren, pc_wren, rd_wren, mem_wren, md_start, wb_md}),
          32'({ST_T, 8'h00}));
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("illegal_async_clear", 32'({state, illegal}), 32'({ST_F, 1'b0}));
    release_rst();

    // MUL with ENABLE_M=0 traps after DECODE
    instr = 32'h022081B3;
    @(negedge clk); imem_ack = 1'b1; #2;
    chk("nm_fetch", 32'({nm_state, nm_ir_wren}), 32'({ST_F, 1'b1}));
    @(negedge clk); imem_ack = 1'b0; #2;
    chk("nm_decode", 32'(nm_state), 32'(ST_D));
    @(negedge clk); #2;
    chk("nm_trap", 32'({nm_state, nm_illegal, state, md_start}), 32'({ST_T, 1'b1, ST_E, 1'b1}));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); imem_ack = 1'b1; dmem_ack = 1'b1; md_done = 1'b1; #2;
      chk($sformatf("nm_quiet[%0d]", c),
          32'({nm_state, nm_imem_req, nm_dmem_req, nm_ir_wren, nm_pc_wren, nm_rd_wren,
               nm_mem_wren, nm_md_start, nm_wb_md}), 32'({ST_T, 8'h00}));
    end

    // Fetch timeout: no ack for 16 cycles
    do_reset();
    instr = 32'h002081B3;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk); imem_ack = 1'b0; #2;
      if (c == 16) chk("to_cycle16", 32'({state, imem_req}), 32'({ST_F, 1'b1}));
    end
    @(negedge clk); #2;
    chk("to_trap", 32'({state, bus_err, illegal, imem_req}), 32'({ST_T, 3'b100}));

    // Fetch ack exactly on cycle 16 completes normally
    do_reset();
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk); imem_ack = (c == 16); #2;
    end
    chk("ack16_ir_wren", 32'(ir_wren), 32'd1);
    @(negedge clk); imem_ack = 1'b0; #2;
    chk("ack16_decode", 32'({state, bus_err}), 32'({ST_D, 1'b0}));

    // Async reset during MEM of a store
    do_reset();
    instr = 32'h0020A023;
    @(negedge clk); imem_ack = 1'b1; #2;
    @(negedge clk); imem_ack = 1'b0; #2;
    @(negedge clk); #2;
    @(negedge clk); dmem_ack = 1'b0; #2;
    chk("sw_in_mem", 32'({state, dmem_req, mem_wren}), 32'({ST_M, 2'b11}));
    rst_n = 1'b0;
    #1;
    chk("sw_mid_reset", 32'({state, dmem_req, mem_wren, pc_wren, imem_req, illegal, bus_err}),
        32'({ST_F, 6'b000100}));
    release_rst();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
